motor_speed_ctrl: RTL and testbench

MOTOR_SPEED_CTRL -- requirements
Module: motor_speed_ctrl

---
 rtl/motor_speed_ctrl_pkg.sv | 17 +
 rtl/motor_speed_ctrl_if.sv | 25 ++
 rtl/motor_speed_ctrl_channel.sv | 173 +++++++++++++++++
 rtl/motor_speed_ctrl.sv | 63 ++++++
 tb/tb_motor_speed_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/motor_speed_ctrl_pkg.sv
// Shared types and default constants for the motor speed controller.
package motor_ctrl_pkg;

  localparam int unsigned DEF_CNT_W      = 20;
  localparam int unsigned DEF_PWM_W      = 8;
  localparam int unsigned DEF_GAIN_SHIFT = 4;
  localparam int unsigned DEF_LOCK_TOL   = 16;
  localparam int unsigned DEF_LOCK_CNT   = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SPINUP   = 2'd1,
    REGULATE = 2'd2,
    STALL    = 2'd3
  } ch_state_e;

endpackage

// File: rtl/motor_speed_ctrl_if.sv
// Run-request, tachometer and status bundle for one or more motor channels.
interface motor_speed_ctrl_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = motor_ctrl_pkg::DEF_CNT_W
) ();

  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH*CNT_W-1:0] target_period;
  logic [NUM_CH-1:0]       feedback_clk;
  logic [NUM_CH-1:0]       motor_ctrl_signal;
  logic [NUM_CH*CNT_W-1:0] measured_period;
  logic [NUM_CH-1:0]       locked;
  logic [NUM_CH-1:0]       stall;

  modport master (
    output enable, target_period, feedback_clk,
    input  motor_ctrl_signal, measured_period, locked, stall
  );

  modport slave (
    input  enable, target_period, feedback_clk,
    output motor_ctrl_signal, measured_period, locked, stall
  );

endinterface

// File: rtl/motor_speed_ctrl_channel.sv
// One motor channel: tach synchronizer, period meter, spin-up/regulate FSM,
// duty integrator with clamping, lock qualification and PWM compare.
module motor_speed_channel
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned PWM_W      = DEF_PWM_W,
  parameter int unsigned GAIN_SHIFT = DEF_GAIN_SHIFT,
  parameter int unsigned LOCK_TOL   = DEF_LOCK_TOL,
  parameter int unsigned LOCK_CNT   = DEF_LOCK_CNT
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic [PWM_W-1:0] pwm_cnt_i,
  motor_speed_ctrl_if.slave bus
);

  localparam int unsigned ERR_W = CNT_W + 1;
  localparam int unsigned SUM_W = ((CNT_W > PWM_W) ? CNT_W : PWM_W) + 2;
  localparam int unsigned LR_W  = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0]        CNT_MAX    = '1;
  localparam logic [PWM_W-1:0]        DUTY_MAX   = '1;
  localparam logic signed [SUM_W-1:0] DUTY_MAX_S = SUM_W'((1 << PWM_W) - 1);
  localparam logic signed [ERR_W-1:0] TOL_P      = ERR_W'(LOCK_TOL);
  localparam logic signed [ERR_W-1:0] TOL_N      = -TOL_P;
  localparam logic [LR_W-1:0]         LOCK_FULL  = LR_W'(LOCK_CNT);

  logic sync1_q, sync2_q, sync3_q;
  logic fb_edge_c;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] meas_q, meas_d;
  logic             mv_q;

  ch_state_e        state_q, state_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic [LR_W-1:0]  lock_q, lock_d;
  logic             locked_q, locked_d;
  logic             stall_q, stall_d;
  logic             motor_q;

  logic signed [ERR_W-1:0] err_c;
  logic signed [ERR_W-1:0] step_c;
  logic signed [SUM_W-1:0] sum_c;
  logic [PWM_W-1:0]        duty_upd_c;
  logic                    sat_c;

  // Two-flop synchronizer plus one flop of history for rising-edge detect.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= bus.feedback_clk[0];
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign fb_edge_c = sync2_q & ~sync3_q;
  assign sat_c     = (cnt_q == CNT_MAX) && !fb_edge_c;

  // Period counter: saturating, restarted by each tach edge which also captures the period.
  always_comb begin
    cnt_d  = cnt_q;
    meas_d = meas_q;
    if (fb_edge_c) begin
      meas_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Period error scaled by the loop gain and added to the duty, clamped to the PWM range.
  always_comb begin
    err_c  = $signed({1'b0, meas_q}) - $signed({1'b0, bus.target_period});
    step_c = err_c >>> GAIN_SHIFT;
    sum_c  = SUM_W'(step_c) + $signed({{(SUM_W - PWM_W){1'b0}}, duty_q});
    if (sum_c < 0) begin
      duty_upd_c = '0;
    end else if (sum_c > DUTY_MAX_S) begin
      duty_upd_c = DUTY_MAX;
    end else begin
      duty_upd_c = sum_c[PWM_W-1:0];
    end
  end

  // Channel FSM next state, duty and lock qualification.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    lock_d  = lock_q;
    unique case (state_q)
      IDLE: begin
        if (bus.enable[0]) begin
          state_d = SPINUP;
          duty_d  = DUTY_MAX;
        end
      end
      SPINUP: begin
        duty_d = DUTY_MAX;
        if (sat_c) begin
          state_d = STALL;
        end else if (mv_q && (meas_q <= bus.target_period)) begin
          state_d = REGULATE;
        end
      end
      REGULATE: begin
        if (sat_c) begin
          state_d = STALL;
        end else if (mv_q) begin
          duty_d = duty_upd_c;
          if ((err_c <= TOL_P) && (err_c >= TOL_N)) begin
            lock_d = (lock_q == LOCK_FULL) ? lock_q : lock_q + LR_W'(1);
          end else begin
            lock_d = '0;
          end
        end
      end
      STALL: begin
        state_d = STALL;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (!bus.enable[0]) begin
      state_d = IDLE;
    end
    if (state_d != REGULATE) begin
      lock_d = '0;
    end
    if ((state_d == IDLE) || (state_d == STALL)) begin
      duty_d = '0;
    end
    locked_d = (state_d == REGULATE) && (lock_d == LOCK_FULL);
    stall_d  = (state_d == STALL);
  end

  // Channel state and registered outputs.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      cnt_q    <= '0;
      meas_q   <= '0;
      mv_q     <= 1'b0;
      state_q  <= IDLE;
      duty_q   <= '0;
      lock_q   <= '0;
      locked_q <= 1'b0;
      stall_q  <= 1'b0;
      motor_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      meas_q   <= meas_d;
      mv_q     <= fb_edge_c;
      state_q  <= state_d;
      duty_q   <= duty_d;
      lock_q   <= lock_d;
      locked_q <= locked_d;
      stall_q  <= stall_d;
      motor_q  <= (pwm_cnt_i < duty_q);
    end
  end

  assign bus.motor_ctrl_signal = motor_q;
  assign bus.measured_period   = meas_q;
  assign bus.locked            = locked_q;
  assign bus.stall             = stall_q;

endmodule

// File: rtl/motor_speed_ctrl.sv
// Multi-channel motor speed controller: shared PWM timebase plus one
// independent closed-loop channel per motor.
module motor_speed_ctrl
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned PWM_W      = DEF_PWM_W,
  parameter int unsigned GAIN_SHIFT = DEF_GAIN_SHIFT,
  parameter int unsigned LOCK_TOL   = DEF_LOCK_TOL,
  parameter int unsigned LOCK_CNT   = DEF_LOCK_CNT
) (
  input  logic                    clk_50,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH*CNT_W-1:0] target_period,
  input  logic [NUM_CH-1:0]       feedback_clk,
  output logic [NUM_CH-1:0]       motor_ctrl_signal,
  output logic [NUM_CH*CNT_W-1:0] measured_period,
  output logic [NUM_CH-1:0]       locked,
  output logic [NUM_CH-1:0]       stall
);

  logic [PWM_W-1:0] pwm_q, pwm_d;

  assign pwm_d = pwm_q + PWM_W'(1);

  // Free-running PWM timebase shared by every channel.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    motor_speed_ctrl_if #(.NUM_CH(1), .CNT_W(CNT_W)) ch_if ();

    assign ch_if.enable        = enable[g];
    assign ch_if.target_period = target_period[g*CNT_W +: CNT_W];
    assign ch_if.feedback_clk  = feedback_clk[g];

    motor_speed_channel #(
      .CNT_W      (CNT_W),
      .PWM_W      (PWM_W),
      .GAIN_SHIFT (GAIN_SHIFT),
      .LOCK_TOL   (LOCK_TOL),
      .LOCK_CNT   (LOCK_CNT)
    ) u_ch (
      .clk_50    (clk_50),
      .reset     (reset),
      .pwm_cnt_i (pwm_q),
      .bus       (ch_if.slave)
    );

    assign motor_ctrl_signal[g]               = ch_if.motor_ctrl_signal[0];
    assign measured_period[g*CNT_W +: CNT_W]  = ch_if.measured_period;
    assign locked[g]                          = ch_if.locked[0];
    assign stall[g]                           = ch_if.stall[0];
  end

endmodule

// File: tb/tb_motor_speed_ctrl.sv
// Bench for motor_speed_ctrl: directed scenarios plus randomized periods on
// channel 0, checked against a per-measurement model of the speed loop.
module tb_motor_speed_ctrl;

  localparam int unsigned NUM_CH     = 2;
  localparam int unsigned CNT_W      = 12;
  localparam int unsigned PWM_W      = 8;
  localparam int unsigned GAIN_SHIFT = 4;
  localparam int unsigned LOCK_TOL   = 16;
  localparam int unsigned LOCK_CNT   = 4;

  localparam int SAT  = 4095;
  localparam int DMAX = 255;

  localparam int M_IDLE  = 0;
  localparam int M_SPIN  = 1;
  localparam int M_REG   = 2;
  localparam int M_STALL = 3;

  logic clk_50 = 1'b0;
  logic reset;

  motor_speed_ctrl_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  motor_speed_ctrl #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .PWM_W      (PWM_W),
    .GAIN_SHIFT (GAIN_SHIFT),
    .LOCK_TOL   (LOCK_TOL),
    .LOCK_CNT   (LOCK_CNT)
  ) dut (
    .clk_50            (clk_50),
    .reset             (reset),
    .enable            (bus.enable),
    .target_period     (bus.target_period),
    .feedback_clk      (bus.feedback_clk),
    .motor_ctrl_signal (bus.motor_ctrl_signal),
    .measured_period   (bus.measured_period),
    .locked            (bus.locked),
    .stall             (bus.stall)
  );

  always #10 clk_50 = ~clk_50;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = -1000;
  bit ch1_watch = 1'b0;
  int np = 0;

  // Channel 0 reference: state, duty, lock run, last measurement, target.
  int m_state = M_IDLE;
  int m_duty  = 0;
  int m_lock  = 0;
  int m_meas  = 0;
  int m_tgt   = 1000;
  int last_raise = -3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  // One clock; ch1 stall timing is checked at fixed cycles after reset release.
  task automatic tick();
    @(posedge clk_50);
    #1;
    cyc++;
    if (ch1_watch) begin
      if (cyc == 4095) chk("ch1_stall_before_sat", 32'(bus.stall[1]), 0);
      if (cyc == 4096) chk("ch1_stall_at_sat", 32'(bus.stall[1]), 1);
      if (cyc == 4100) begin
        chk("ch1_pwm_low_in_stall", 32'(bus.motor_ctrl_signal[1]), 0);
        chk("ch1_meas_no_edges", 32'(bus.measured_period[CNT_W +: CNT_W]), 0);
      end
    end
  endtask

  task automatic set_en0(input bit en);
    bus.enable[0] = en;
    if (!en) begin
      m_state = M_IDLE;
      m_duty  = 0;
      m_lock  = 0;
    end else if (m_state == M_IDLE) begin
      m_state = M_SPIN;
      m_duty  = DMAX;
    end
  endtask

  task automatic set_tgt(input int tgt);
    bus.target_period[0 +: CNT_W] = CNT_W'(tgt);
    m_tgt = tgt;
  endtask

  // Tach pulse on ch0; the next pulse starts 'period' cycles later. The
  // measurement taken by this pulse is the spacing since the previous one.
  task automatic pulse0(input int period);
    int gap;
    int m;
    int err;
    int hi;
    gap = cyc - last_raise;
    last_raise = cyc;
    np++;
    if (((m_state == M_SPIN) || (m_state == M_REG)) && (gap > SAT + 1)) begin
      m_state = M_STALL;
      m_duty  = 0;
      m_lock  = 0;
    end
    m = (gap > SAT) ? SAT : gap;
    m_meas = m;
    if (m_state == M_SPIN) begin
      if (m <= m_tgt) m_state = M_REG;
    end else if (m_state == M_REG) begin
      err = m - m_tgt;
      m_duty = m_duty + (err >>> GAIN_SHIFT);
      if (m_duty < 0) m_duty = 0;
      if (m_duty > DMAX) m_duty = DMAX;
      if ((err <= int'(LOCK_TOL)) && (err >= -int'(LOCK_TOL))) begin
        m_lock = (m_lock >= int'(LOCK_CNT)) ? int'(LOCK_CNT) : m_lock + 1;
      end else begin
        m_lock = 0;
      end
    end
    bus.feedback_clk[0] = 1'b1;
    hi = 0;
    for (int i = 1; i <= period; i++) begin
      tick();
      if (i == 20) bus.feedback_clk[0] = 1'b0;
      if (i == 8) begin
        chk($sformatf("p%0d_meas", np), 32'(bus.measured_period[0 +: CNT_W]), m_meas);
        chk($sformatf("p%0d_locked", np), 32'(bus.locked[0]),
            ((m_state == M_REG) && (m_lock == int'(LOCK_CNT))) ? 1 : 0);
        chk($sformatf("p%0d_stall", np), 32'(bus.stall[0]), (m_state == M_STALL) ? 1 : 0);
      end
      if ((i >= 8) && (i < 264)) hi += int'(bus.motor_ctrl_signal[0]);
      if (i == 264) chk($sformatf("p%0d_duty", np), hi, m_duty);
    end
  endtask

  initial begin
    int tgt;
    int hi;

    // Reset with both channels requesting run: every output held at zero.
    reset = 1'b1;
    bus.enable = 2'b11;
    bus.target_period = {12'd1000, 12'd1000};
    bus.feedback_clk = 2'b00;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_motor", 32'(bus.motor_ctrl_signal), 0);
      chk("rst_meas", 32'(bus.measured_period), 0);
      chk("rst_locked", 32'(bus.locked), 0);
      chk("rst_stall", 32'(bus.stall), 0);
    end

    // Release: ch1 runs with no tach (will stall), ch0 idles for a priming edge.
    reset = 1'b0;
    bus.enable = 2'b10;
    cyc = 0;
    ch1_watch = 1'b1;
    set_tgt(1000);
    repeat (10) tick();
    pulse0(2000);

    // Spin-up: 2000 keeps SPINUP, 1000 enters REGULATE, four more on-target edges lock.
    set_en0(1'b1);
    pulse0(1000);
    pulse0(1000);
    for (int k = 0; k < 4; k++) pulse0(1000);
    chk("locked_after_4_on_target", 32'(bus.locked[0]), 1);

    // Dropping enable while locked: lock clears next cycle, PWM low the cycle after.
    set_en0(1'b0);
    tick();
    chk("drop_en_locked", 32'(bus.locked[0]), 0);
    chk("drop_en_stall", 32'(bus.stall[0]), 0);
    tick();
    chk("drop_en_pwm_low", 32'(bus.motor_ctrl_signal[0]), 0);
    hi = 0;
    for (int k = 0; k < 256; k++) begin
      tick();
      hi += int'(bus.motor_ctrl_signal[0]);
    end
    chk("idle_pwm_window", hi, 0);

    // Walk duty down to 10, then an error of -320 must clamp at 0 rather than wrap.
    set_tgt(2000);
    set_en0(1'b1);
    pulse0(1000);
    pulse0(1000);
    pulse0(1000);
    pulse0(1104);
    pulse0(1000);
    chk("duty_is_10_model", m_duty, 10);
    set_tgt(1320);
    pulse0(1000);
    chk("duty_clamped_model", m_duty, 0);

    // Randomized targets and periods around them.
    for (int t = 0; t < 3; t++) begin
      tgt = int'($urandom_range(900, 1100));
      set_tgt(tgt);
      for (int k = 0; k < 5; k++) begin
        pulse0(tgt + int'($urandom_range(0, 40)) - 20);
      end
    end

    // Edge landing exactly as the period counter saturates: measure 4095, no stall.
    set_tgt(4000);
    pulse0(4096);
    pulse0(500);
    chk("sat_edge_meas", 32'(bus.measured_period[0 +: CNT_W]), SAT);
    chk("sat_edge_no_stall", 32'(bus.stall[0]), 0);

    // Reset mid-operation forces all outputs low on the next edge.
    reset = 1'b1;
    tick();
    chk("midrst_motor", 32'(bus.motor_ctrl_signal), 0);
    chk("midrst_meas", 32'(bus.measured_period), 0);
    chk("midrst_locked", 32'(bus.locked), 0);
    chk("midrst_stall", 32'(bus.stall), 0);
    tick();
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
